vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Free-running 640x480@60 raster timing generator in the pixel_clk domain. Sits directly upstream of video_gen and drives its pixel_x, pixel_y, hsync, vsync and video_on inputs. Also provides line/frame strobes and a frame counter for game-logic pacing (player update once per frame).

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync asserted low

Ports:
pixel_clk  in  1  pixel clock (25 MHz); the only clock
reset  in  1  synchronous, active-high reset
pix_en  in  1  advance one pixel when high; tie to 1 for 1 pixel/clk
pixel_x  out  10  horizontal count, 0..H_TOTAL-1; visible area is 0..H_VISIBLE-1
pixel_y  out  10  vertical count, 0..V_TOTAL-1; visible area is 0..V_VISIBLE-1
hsync  out  1  horizontal sync, polarity per SYNC_ACTIVE_LOW
vsync  out  1  vertical sync, polarity per SYNC_ACTIVE_LOW
video_on  out  1  high when pixel_x < H_VISIBLE and pixel_y < V_VISIBLE
line_start  out  1  high while pixel_x == 0
frame_start  out  1  high while pixel_x == 0 and pixel_y == 0
frame_count  out  16  frame index; increments on each entry to (0,0)

Behaviour:
- Clock and reset: one clock, pixel_clk. reset is synchronous and active-high and is sampled only on the pixel_clk rising edge.
- Derived constants:
  - H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800).
  - V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
  - Both must be ≤ 1024; elaboration-time assertion otherwise.
- Registered outputs: every output is a register. Counters and all outputs update together on a pix_en cycle, so the outputs always describe the coordinate currently on pixel_x/pixel_y. There is no skew between any outputs.
- Reset state (any cycle with reset=1, regardless of pix_en):
  - pixel_x = H_TOTAL-1, pixel_y = V_TOTAL-1 (last pixel of a frame).
  - video_on = 0, line_start = 0, frame_start = 0.
  - hsync and vsync inactive (1 when SYNC_ACTIVE_LOW).
  - frame_count = 16'hFFFF.
- First pixel after reset: the first pix_en cycle after reset deasserts presents (0,0) with frame_start=1, line_start=1, video_on=1 and frame_count=0.
- Advance rule, on pix_en=1:
  - If pixel_x == H_TOTAL-1: pixel_x wraps to 0.
  - Else: pixel_x increments by 1.
  - pixel_y increments only when pixel_x wraps; it wraps to 0 when pixel_x wraps while pixel_y == V_TOTAL-1.
  - frame_count increments (mod 2^16, 0xFFFF→0) on the same cycle both counters wrap.
- Stall: when pix_en=0, all outputs and counters hold. Strobes are levels tied to the coordinate and stay high across stalls; consumers qualify them with pix_en.
- hsync assertion window:
  - Active for pixel_x in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. [656, 751].
  - Independent of pixel_y.
- vsync assertion window:
  - Active for pixel_y in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. [490, 491].
  - Spans whole lines.
- Output decode: all output decodes are computed from the next-count values, so each registered output matches its coordinate.
- Frame period: exactly H_TOTAL×V_TOTAL = 420000 pix_en cycles per frame.
- Reset priority: reset mid-frame overrides pix_en. The next edge loads the reset state, and the raster restarts at (0,0) on the following pix_en.

Decomposition:
- Shared package (starsoc_params): the timing constants listed above, plus H_TOTAL and V_TOTAL. video_gen's existing h_visible and visible_origin constants derive from the same values.
- Sub-module mod_counter: one natural sub-module.
  - Parameter MOD.
  - Ports: pixel_clk, reset, en, count[9:0], wrap (combinational carry-out, high when en and count == MOD-1).
  - Reset value of count is MOD-1.
  - Instantiated twice: horizontal counter with en = pix_en; vertical counter with en = horizontal wrap.
- Sync/strobe decode and frame_count live in the top level.

Test Plan:
1. Reset held 3 cycles with pix_en=1 → pixel_x=799, pixel_y=524, hsync=vsync=1, video_on=0, frame_count=0xFFFF. First cycle after release → (0,0), frame_start=1, line_start=1, video_on=1, frame_count=0.
2. pix_en=1, step pixel_x 639→640→655→656→751→752 on line 0 → video_on falls at 640. hsync=0 exactly for 656..751 (96 cycles), 1 at 752.
3. Line wrap at (799,0) → next (0,1), line_start=1, frame_start=0. vsync=0 exactly for lines 490–491 (1600 pix_en cycles).
4. Frame wrap at (799,524) → (0,0), frame_start=1, frame_count 0→1. Measured frame period is 420000 cycles. Force frame_count=0xFFFF and wrap → 0.
5. Toggle pix_en pseudo-randomly (50%) for 2 frames → outputs never change on pix_en=0 cycles. Sequence of coordinates identical to the pix_en=1 run; frame period is 420000 pix_en cycles.
6. Assert reset for 1 cycle at (300,200) with pix_en=1 → next cycle shows the reset state. The cycle after shows (0,0), frame_start=1, frame_count=0.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// starsoc_params: shared 640x480@60 raster timing constants and decode helper
package starsoc_params;

    localparam int H_VISIBLE       = 640;
    localparam int H_FRONT         = 16;
    localparam int H_SYNC          = 96;
    localparam int H_BACK          = 48;
    localparam int V_VISIBLE       = 480;
    localparam int V_FRONT         = 10;
    localparam int V_SYNC          = 2;
    localparam int V_BACK          = 33;
    localparam int SYNC_ACTIVE_LOW = 1;
    localparam int H_TOTAL         = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL         = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // True when coordinate v lies in [lo, lo+len-1]
    function automatic logic in_window(input logic [9:0] v, input int lo, input int len);
        return (int'({22'd0, v}) >= lo) && (int'({22'd0, v}) < lo + len);
    endfunction

endpackage

// File: rtl/vga_timing_gen_mod_counter.sv
// mod_counter: modulo-MOD up counter with combinational wrap carry, resets to MOD-1
module mod_counter #(
    parameter int MOD = 800
) (
    input  logic       pixel_clk,
    input  logic       reset,
    input  logic       en,
    output logic [9:0] count,
    output logic       wrap
);

    localparam logic [9:0] LAST = 10'(MOD - 1);

    assign wrap = en && (count == LAST);

    // Reset parks on the last value so the first enabled cycle presents 0
    always_ff @(posedge pixel_clk) begin
        if (reset)   count <= LAST;
        else if (en) count <= wrap ? '0 : count + 10'd1;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running raster timing with registered sync, strobes and frame counter
module vga_timing_gen
    import starsoc_params::*;
#(
    parameter int H_VISIBLE       = starsoc_params::H_VISIBLE,
    parameter int H_FRONT         = starsoc_params::H_FRONT,
    parameter int H_SYNC          = starsoc_params::H_SYNC,
    parameter int H_BACK          = starsoc_params::H_BACK,
    parameter int V_VISIBLE       = starsoc_params::V_VISIBLE,
    parameter int V_FRONT         = starsoc_params::V_FRONT,
    parameter int V_SYNC          = starsoc_params::V_SYNC,
    parameter int V_BACK          = starsoc_params::V_BACK,
    parameter int SYNC_ACTIVE_LOW = starsoc_params::SYNC_ACTIVE_LOW
) (
    input  logic        pixel_clk,
    input  logic        reset,
    input  logic        pix_en,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int   H_TOT   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int   V_TOT   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic SYNC_ON = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

    if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_timing
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
    end

    logic       w_h_wrap;
    logic       w_v_wrap;
    logic [9:0] w_x_next;
    logic [9:0] w_y_next;

    mod_counter #(.MOD(H_TOT)) u_h_cnt (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .en        (pix_en),
        .count     (pixel_x),
        .wrap      (w_h_wrap)
    );

    mod_counter #(.MOD(V_TOT)) u_v_cnt (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .en        (w_h_wrap),
        .count     (pixel_y),
        .wrap      (w_v_wrap)
    );

    // Decode looks at the coordinate the counters are about to load so outputs stay aligned
    assign w_x_next = w_h_wrap ? '0 : pixel_x + 10'd1;
    assign w_y_next = w_v_wrap ? '0 : (w_h_wrap ? pixel_y + 10'd1 : pixel_y);

    // Registered sync, strobes and frame index; everything holds while pix_en is low
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            hsync       <= ~SYNC_ON;
            vsync       <= ~SYNC_ON;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 16'hFFFF;
        end else if (pix_en) begin
            hsync       <= in_window(w_x_next, H_VISIBLE + H_FRONT, H_SYNC) ? SYNC_ON : ~SYNC_ON;
            vsync       <= in_window(w_y_next, V_VISIBLE + V_FRONT, V_SYNC) ? SYNC_ON : ~SYNC_ON;
            video_on    <= in_window(w_x_next, 0, H_VISIBLE) && in_window(w_y_next, 0, V_VISIBLE);
            line_start  <= (w_x_next == '0);
            frame_start <= (w_x_next == '0) && (w_y_next == '0);
            frame_count <= frame_count + 16'(w_v_wrap);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized self-checking bench against a linear-position raster model
module tb_vga_timing_gen;

    localparam int HV = 16, HF = 4, HS = 6, HB = 6;
    localparam int VV = 12, VF = 2, VS = 2, VB = 4;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_en = 1'b1;
    logic [9:0]  pixel_x, pixel_y;
    logic        hsync, vsync, video_on, line_start, frame_start;
    logic [15:0] frame_count;

    int          checks = 0;
    int          failures = 0;
    int          pos = FT - 1;
    logic [15:0] m_fc = 16'hFFFF;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE_LOW(1)
    ) dut (
        .pixel_clk   (clk),
        .reset       (reset),
        .pix_en      (pix_en),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .line_start  (line_start),
        .frame_start (frame_start),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (pos=%0d)", tag, obs, exp, pos);
        end
    endtask

    task automatic check_model();
        int ex, ey;
        ex = pos % HT;
        ey = pos / HT;
        check("pixel_x", 16'(pixel_x), 16'(ex));
        check("pixel_y", 16'(pixel_y), 16'(ey));
        check("hsync", 16'(hsync), 16'(!(ex >= HV + HF && ex < HV + HF + HS)));
        check("vsync", 16'(vsync), 16'(!(ey >= VV + VF && ey < VV + VF + VS)));
        check("video_on", 16'(video_on), 16'(ex < HV && ey < VV));
        check("line_start", 16'(line_start), 16'(ex == 0));
        check("frame_start", 16'(frame_start), 16'(pos == 0));
        check("frame_count", frame_count, m_fc);
    endtask

    task automatic step(input logic en, input logic r);
        pix_en = en;
        reset  = r;
        @(posedge clk);
        #1;
        if (r) begin
            pos  = FT - 1;
            m_fc = 16'hFFFF;
        end else if (en) begin
            pos = (pos + 1) % FT;
            if (pos == 0) m_fc = m_fc + 16'd1;
        end
        check_model();
    endtask

    initial begin
        int cnt, n_hs, n_vs, n_vo, n_ls, en_cnt, hits;
        logic e;
        // reset held three cycles with pix_en high
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        check("rst_x", 16'(pixel_x), 16'(HT - 1));
        check("rst_y", 16'(pixel_y), 16'(VT - 1));
        check("rst_fc", frame_count, 16'hFFFF);
        // first pixel after release
        step(1'b1, 1'b0);
        check("first_fs", 16'(frame_start), 16'd1);
        check("first_fc", frame_count, 16'd0);
        // one full frame at pix_en=1 with window measurements
        cnt = 0; n_hs = 0; n_vs = 0; n_vo = 0; n_ls = 0;
        do begin
            n_hs += int'(hsync == 1'b0);
            n_vs += int'(vsync == 1'b0);
            n_vo += int'(video_on);
            n_ls += int'(line_start);
            step(1'b1, 1'b0);
            cnt++;
        end while (!frame_start && cnt < 2 * FT);
        check("frame_period", 16'(cnt), 16'(FT));
        check("hsync_cycles", 16'(n_hs), 16'(HS * VT));
        check("vsync_cycles", 16'(n_vs), 16'(VS * HT));
        check("video_cycles", 16'(n_vo), 16'(HV * VV));
        check("line_starts", 16'(n_ls), 16'(VT));
        check("fc_after_wrap", frame_count, 16'd1);
        // random pix_en: period in enabled cycles between frame entries
        en_cnt = 0; hits = 0;
        for (int i = 0; i < 8 * FT && hits < 2; i++) begin
            e = 1'($urandom % 2);
            step(e, 1'b0);
            if (e) en_cnt++;
            if (e && frame_start) begin
                if (hits == 0) en_cnt = 0;
                hits++;
            end
        end
        check("rand_frame_period", 16'(en_cnt), 16'(FT));
        // mid-frame reset inside the hsync window
        for (int i = 0; i < 2 * FT && pos != 7 * HT + 20; i++) step(1'b1, 1'b0);
        check("pre_rst_x", 16'(pixel_x), 16'd20);
        step(1'b1, 1'b1);
        check("mid_rst_x", 16'(pixel_x), 16'(HT - 1));
        check("mid_rst_hs", 16'(hsync), 16'd1);
        step(1'b1, 1'b0);
        check("restart_fs", 16'(frame_start), 16'd1);
        check("restart_fc", frame_count, 16'd0);
        // random pix_en with rare resets
        for (int i = 0; i < 3 * FT; i++) step(1'($urandom % 4 != 0), 1'($urandom % 300 == 0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
